spm_writeback_buffer: RTL and testbench

- Result buffer and load formatter between the scratchpad memory pipe output and the writeback stage.
- Absorbs every SPM completion, since the SPM pipe output has no stall input.
- Drops store completions, sign-extends signed sub-word loads, and presents load results to writeback through a valid/ready handshake.
- Exports an almost-full flag that the dynamic scheduler ANDs into the SPM issue permission.

---
 rtl/spm_writeback_buffer_pkg.sv | 67 ++++++
 rtl/spm_writeback_buffer_sync_fifo.sv | 53 +++++
 rtl/spm_writeback_buffer.sv | 92 +++++++++
 tb/tb_spm_writeback_buffer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spm_writeback_buffer_pkg.sv
// Shared SPM writeback types: lane data, decoded instruction, buffered entry,
// and the sub-word load sign-extension helper.
package spm_writeback_buffer_pkg;

  localparam int unsigned HW_LANE  = 16;
  localparam int unsigned REG_W    = 32;
  localparam int unsigned PC_W     = 32;
  localparam int unsigned THREAD_W = 2;

  typedef logic [REG_W-1:0]        register_t;
  typedef register_t [HW_LANE-1:0] hw_lane_t;
  typedef logic [HW_LANE-1:0]      hw_lane_mask_t;

  typedef enum logic [4:0] {
    LOAD_8,
    LOAD_8_U,
    LOAD_16,
    LOAD_16_U,
    LOAD_32,
    LOAD_V_8,
    LOAD_V_8_U,
    LOAD_V_16,
    LOAD_V_16_U,
    LOAD_V_32,
    LOAD_G_8,
    LOAD_G_8_U,
    LOAD_G_16,
    LOAD_G_16_U,
    LOAD_G_32,
    STORE_8,
    STORE_16,
    STORE_32,
    STORE_V_32,
    STORE_G_32
  } mem_opcode_t;

  typedef struct packed {
    logic [PC_W-1:0]     pc;
    logic [THREAD_W-1:0] thread_id;
    logic                is_load;
    logic                is_store;
    mem_opcode_t         mem_opcode;
  } instruction_decoded_t;

  typedef struct packed {
    instruction_decoded_t inst;
    hw_lane_t             data;
    hw_lane_mask_t        mask;
  } spm_wb_entry_t;

  localparam int unsigned INST_W  = $bits(instruction_decoded_t);
  localparam int unsigned DATA_W  = $bits(hw_lane_t);
  localparam int unsigned ENTRY_W = $bits(spm_wb_entry_t);

  // Signed sub-word loads replicate their top data bit; everything else passes.
  function automatic register_t spm_load_sign_extend(input mem_opcode_t op, input register_t d);
    register_t r;
    r = d;
    case (op)
      LOAD_8, LOAD_V_8, LOAD_G_8:    r = {{24{d[7]}}, d[7:0]};
      LOAD_16, LOAD_V_16, LOAD_G_16: r = {{16{d[15]}}, d[15:0]};
      default:                       r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/spm_writeback_buffer_sync_fifo.sv
// Synchronous-reset FIFO with occupancy count; storage is not reset and the
// head entry is read straight from the storage array.
module spm_writeback_buffer_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count_q;
  logic             rd_en;
  logic             wr_en;

  assign rd_en = pop && (count_q != '0);
  assign wr_en = push && ((count_q != CW'(DEPTH)) || rd_en);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      count_q <= count_q + CW'(wr_en) - CW'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign count   = count_q;
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));

endmodule

// File: rtl/spm_writeback_buffer.sv
// Buffers SPM load completions for writeback: drops stores, sign-extends signed
// sub-word loads, and flags almost-full / lost-completion conditions.
module spm_writeback_buffer
  import spm_writeback_buffer_pkg::*;
#(
  parameter int unsigned DEPTH                 = 4,
  parameter int unsigned ALMOST_FULL_THRESHOLD = DEPTH - 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               spm_valid,
  input  logic [INST_W-1:0]  spm_inst_scheduled,
  input  logic [DATA_W-1:0]  spm_result,
  input  logic [HW_LANE-1:0] spm_hw_lane_mask,
  input  logic               wb_ready,
  output logic               wb_valid,
  output logic [INST_W-1:0]  wb_inst_scheduled,
  output logic [DATA_W-1:0]  wb_result,
  output logic [HW_LANE-1:0] wb_hw_lane_mask,
  output logic               spm_wb_almost_full,
  output logic               spm_wb_overflow
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  instruction_decoded_t in_inst;
  hw_lane_t             in_data;
  hw_lane_t             fmt_data;
  spm_wb_entry_t        wr_entry;
  spm_wb_entry_t        rd_entry;
  logic [ENTRY_W-1:0]   rd_bits;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [CW-1:0]        count;
  logic [CW-1:0]        count_next;
  logic                 almost_full_q;
  logic                 overflow_q;

  // Per-lane load formatting ahead of the storage write.
  always_comb begin
    in_inst  = instruction_decoded_t'(spm_inst_scheduled);
    in_data  = hw_lane_t'(spm_result);
    fmt_data = '0;
    for (int unsigned i = 0; i < HW_LANE; i++) begin
      fmt_data[i] = spm_load_sign_extend(in_inst.mem_opcode, in_data[i]);
    end
    wr_entry = '{inst: in_inst, data: fmt_data, mask: spm_hw_lane_mask};
  end

  // A full buffer still accepts when the head leaves in the same cycle.
  assign accept     = spm_valid && in_inst.is_load;
  assign pop        = !fifo_empty && wb_ready;
  assign push       = accept && (!fifo_full || pop);
  assign count_next = count + CW'(push) - CW'(pop);

  spm_writeback_buffer_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (rd_bits),
    .count   (count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      almost_full_q <= (count_next >= CW'(ALMOST_FULL_THRESHOLD));
      if (accept && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  assign rd_entry           = spm_wb_entry_t'(rd_bits);
  assign wb_valid           = !fifo_empty;
  assign wb_inst_scheduled  = rd_entry.inst;
  assign wb_result          = rd_entry.data;
  assign wb_hw_lane_mask    = rd_entry.mask;
  assign spm_wb_almost_full = almost_full_q;
  assign spm_wb_overflow    = overflow_q;

endmodule

// File: tb/tb_spm_writeback_buffer.sv
// Scoreboard bench for spm_writeback_buffer: directed loads/stores push expected
// entries; a monitor pops and compares on every writeback handshake.
module tb_spm_writeback_buffer;
  import spm_writeback_buffer_pkg::*;

  logic               clk;
  logic               reset;
  logic               spm_valid;
  logic [INST_W-1:0]  spm_inst_scheduled;
  logic [DATA_W-1:0]  spm_result;
  logic [HW_LANE-1:0] spm_hw_lane_mask;
  logic               wb_ready;
  logic               wb_valid;
  logic [INST_W-1:0]  wb_inst_scheduled;
  logic [DATA_W-1:0]  wb_result;
  logic [HW_LANE-1:0] wb_hw_lane_mask;
  logic               spm_wb_almost_full;
  logic               spm_wb_overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int n_xfer   = 0;
  int xfer0;
  spm_wb_entry_t exp_q[$];

  spm_writeback_buffer #(.DEPTH(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .spm_valid          (spm_valid),
    .spm_inst_scheduled (spm_inst_scheduled),
    .spm_result         (spm_result),
    .spm_hw_lane_mask   (spm_hw_lane_mask),
    .wb_ready           (wb_ready),
    .wb_valid           (wb_valid),
    .wb_inst_scheduled  (wb_inst_scheduled),
    .wb_result          (wb_result),
    .wb_hw_lane_mask    (wb_hw_lane_mask),
    .spm_wb_almost_full (spm_wb_almost_full),
    .spm_wb_overflow    (spm_wb_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic hw_lane_t lanes(input register_t lane0, input register_t rest);
    hw_lane_t l;
    for (int i = 0; i < HW_LANE; i++) l[i] = (i == 0) ? lane0 : rest;
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one completion; queue its expected formatted entry if it should survive.
  task automatic drive(input logic [31:0] pc, input mem_opcode_t op, input logic ld,
                       input hw_lane_t din, input hw_lane_t dexp,
                       input logic [15:0] mask, input logic keep);
    instruction_decoded_t t;
    spm_wb_entry_t        e;
    t.pc         = pc;
    t.thread_id  = pc[3:2];
    t.is_load    = ld;
    t.is_store   = !ld;
    t.mem_opcode = op;
    spm_valid          = 1'b1;
    spm_inst_scheduled = t;
    spm_result         = din;
    spm_hw_lane_mask   = mask;
    if (keep) begin
      e.inst = t;
      e.data = dexp;
      e.mask = mask;
      exp_q.push_back(e);
    end
  endtask

  task automatic load32(input logic [31:0] pc, input register_t v, input logic keep);
    drive(pc, LOAD_32, 1'b1, lanes(v, 32'h0), lanes(v, 32'h0), 16'h0001, keep);
  endtask

  initial begin : monitor
    spm_wb_entry_t got;
    spm_wb_entry_t e;
    forever begin
      @(negedge clk);
      if (!reset && wb_valid && wb_ready) begin
        got.inst = instruction_decoded_t'(wb_inst_scheduled);
        got.data = hw_lane_t'(wb_result);
        got.mask = wb_hw_lane_mask;
        n_checks++;
        n_xfer++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL wb_unexpected: got pc %h, expected no transfer", got.inst.pc);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_fail++;
            $display("FAIL wb_entry: got pc=%h mask=%h data=%h expected pc=%h mask=%h data=%h",
                     got.inst.pc, got.mask, got.data, e.inst.pc, e.mask, e.data);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion before 200000");
    $fatal(1);
  end

  initial begin : stimulus
    reset              = 1'b1;
    spm_valid          = 1'b0;
    wb_ready           = 1'b0;
    spm_inst_scheduled = '0;
    spm_result         = '0;
    spm_hw_lane_mask   = '0;
    tick();
    tick();
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_almost_full", 32'(spm_wb_almost_full), 32'd0);
    check("rst_overflow", 32'(spm_wb_overflow), 32'd0);
    reset = 1'b0;

    // Signed byte, one-cycle latency, then empty again
    wb_ready = 1'b1;
    drive(32'h100, LOAD_8, 1'b1, lanes(32'h000000F3, 32'h0), lanes(32'hFFFFFFF3, 32'h0), 16'h0001, 1'b1);
    tick();
    spm_valid = 1'b0;
    check("sx8_valid", 32'(wb_valid), 32'd1);
    check("sx8_lane0", wb_result[31:0], 32'hFFFFFFF3);
    tick();
    check("sx8_drained", 32'(wb_valid), 32'd0);

    // Format table across opcodes
    drive(32'h104, LOAD_16_U, 1'b1, lanes(32'h00008001, 32'h0), lanes(32'h00008001, 32'h0), 16'h0001, 1'b1);
    tick();
    drive(32'h108, LOAD_V_16, 1'b1, lanes(32'h00008001, 32'h00008001), lanes(32'hFFFF8001, 32'hFFFF8001), 16'hFFFF, 1'b1);
    tick();
    drive(32'h10C, LOAD_8_U, 1'b1, lanes(32'h000000F3, 32'h0), lanes(32'h000000F3, 32'h0), 16'h0001, 1'b1);
    tick();
    drive(32'h110, LOAD_G_8, 1'b1, lanes(32'h0000007F, 32'h00000080), lanes(32'h0000007F, 32'hFFFFFF80), 16'h00FF, 1'b1);
    tick();
    drive(32'h114, LOAD_G_16, 1'b1, lanes(32'h0000F00F, 32'h00007FFF), lanes(32'hFFFFF00F, 32'h00007FFF), 16'h0F0F, 1'b1);
    tick();
    drive(32'h118, LOAD_32, 1'b1, lanes(32'h80000000, 32'h0), lanes(32'h80000000, 32'h0), 16'h0001, 1'b1);
    tick();
    spm_valid = 1'b0;
    tick();
    tick();
    check("fmt_drained", 32'(wb_valid), 32'd0);

    // Stores interleaved with loads: only loads reach writeback
    xfer0 = n_xfer;
    drive(32'h200, STORE_32, 1'b0, lanes(32'hDEADBEEF, 32'h0), lanes(32'h0, 32'h0), 16'h0001, 1'b0);
    tick();
    load32(32'h204, 32'h11111111, 1'b1);
    tick();
    drive(32'h208, STORE_32, 1'b0, lanes(32'hDEADBEEF, 32'h0), lanes(32'h0, 32'h0), 16'h0001, 1'b0);
    tick();
    load32(32'h20C, 32'h22222222, 1'b1);
    tick();
    drive(32'h210, STORE_32, 1'b0, lanes(32'hDEADBEEF, 32'h0), lanes(32'h0, 32'h0), 16'h0001, 1'b0);
    tick();
    spm_valid = 1'b0;
    tick();
    tick();
    check("st_filter_xfers", 32'(n_xfer - xfer0), 32'd2);
    check("st_filter_valid", 32'(wb_valid), 32'd0);
    check("st_filter_ovf", 32'(spm_wb_overflow), 32'd0);

    // Backpressure: head frozen, almost-full from the 2nd entry
    wb_ready = 1'b0;
    load32(32'h300, 32'hA1, 1'b1);
    tick();
    check("bp1_af", 32'(spm_wb_almost_full), 32'd0);
    check("bp1_head", wb_result[31:0], 32'hA1);
    load32(32'h304, 32'hA2, 1'b1);
    tick();
    check("bp2_af", 32'(spm_wb_almost_full), 32'd1);
    check("bp2_head", wb_result[31:0], 32'hA1);
    load32(32'h308, 32'hA3, 1'b1);
    tick();
    check("bp3_head", wb_result[31:0], 32'hA1);
    load32(32'h30C, 32'hA4, 1'b1);
    tick();
    spm_valid = 1'b0;
    check("bp4_head", wb_result[31:0], 32'hA1);
    check("bp4_ovf", 32'(spm_wb_overflow), 32'd0);
    xfer0    = n_xfer;
    wb_ready = 1'b1;
    tick();
    check("drain1_xfers", 32'(n_xfer - xfer0), 32'd1);
    check("drain1_af", 32'(spm_wb_almost_full), 32'd1);
    tick();
    check("drain2_xfers", 32'(n_xfer - xfer0), 32'd2);
    check("drain2_af", 32'(spm_wb_almost_full), 32'd1);
    tick();
    check("drain3_xfers", 32'(n_xfer - xfer0), 32'd3);
    check("drain3_af", 32'(spm_wb_almost_full), 32'd0);
    tick();
    check("drain4_xfers", 32'(n_xfer - xfer0), 32'd4);
    check("drain4_valid", 32'(wb_valid), 32'd0);

    // Full with simultaneous enq/deq, then a dropped completion
    wb_ready = 1'b0;
    load32(32'h400, 32'hB5, 1'b1);
    tick();
    load32(32'h404, 32'hB6, 1'b1);
    tick();
    load32(32'h408, 32'hB7, 1'b1);
    tick();
    load32(32'h40C, 32'hB8, 1'b1);
    tick();
    wb_ready = 1'b1;
    load32(32'h410, 32'hB9, 1'b1);
    tick();
    check("full_both_ovf", 32'(spm_wb_overflow), 32'd0);
    check("full_both_af", 32'(spm_wb_almost_full), 32'd1);
    check("full_both_head", wb_result[31:0], 32'hB6);
    wb_ready = 1'b0;
    load32(32'h414, 32'hBA, 1'b0);
    tick();
    spm_valid = 1'b0;
    check("ovf_set", 32'(spm_wb_overflow), 32'd1);
    check("ovf_head", wb_result[31:0], 32'hB6);
    tick();
    tick();
    check("ovf_sticky", 32'(spm_wb_overflow), 32'd1);
    wb_ready = 1'b1;
    repeat (4) tick();
    check("ovf_drained", 32'(wb_valid), 32'd0);
    tick();
    check("ovf_still_set", 32'(spm_wb_overflow), 32'd1);

    // Reset mid-operation discards contents and clears flags
    wb_ready = 1'b0;
    load32(32'h500, 32'hC1, 1'b1);
    tick();
    load32(32'h504, 32'hC2, 1'b1);
    tick();
    load32(32'h508, 32'hC3, 1'b1);
    tick();
    spm_valid = 1'b0;
    check("pre_rst_af", 32'(spm_wb_almost_full), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    check("mid_rst_valid", 32'(wb_valid), 32'd0);
    check("mid_rst_af", 32'(spm_wb_almost_full), 32'd0);
    check("mid_rst_ovf", 32'(spm_wb_overflow), 32'd0);
    wb_ready = 1'b1;
    load32(32'h600, 32'hD1, 1'b1);
    tick();
    spm_valid = 1'b0;
    check("post_rst_valid", 32'(wb_valid), 32'd1);
    check("post_rst_head", wb_result[31:0], 32'hD1);
    tick();
    check("post_rst_drained", 32'(wb_valid), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
